bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the 3-digit seven-segment decoder.
- Its packed BCD output feeds the decoder's 12-bit digit input: digit 2 in [11:8], digit 1 in [7:4], digit 0 in [3:0].
- Start/busy/done handshake; output holds the last result between conversions.

Parameters:
- WIDTH, 10, binary input width in bits (>=4).
- DIGITS, 3, number of BCD output digits; max representable value MAXV = 10^DIGITS - 1.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  WIDTH  unsigned binary value; sampled on the edge where start is accepted.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when a new result is written to bcd.
- ovf  output  1  high if the last accepted bin exceeded MAXV; updated together with bcd.
- bcd  output  4*DIGITS  packed BCD result, most-significant digit in the top nibble.

Behaviour:
- Reset: rst_n low at a clock edge forces state=IDLE, busy=0, done=0, ovf=0, bcd=0, and clears internal scratch and counter.
  - Reset mid-conversion aborts the conversion; no done pulse follows.
- States: IDLE, SHIFT.
- IDLE with start=1 at edge E0:
  - Latch operand = (bin > MAXV) ? MAXV : bin.
  - Latch pending_ovf = (bin > MAXV).
  - Clear the BCD scratch (4*DIGITS bits) and set the bit counter to WIDTH.
  - Go to SHIFT.
- IDLE with start=0: hold all outputs; done=0.
- SHIFT, each edge:
  - Every scratch digit >= 5 gets +3, combinationally, before the shift.
  - Shift {scratch, operand} left by one.
  - Decrement the counter.
- SHIFT, last shift (counter==1):
  - Write the post-shift scratch into bcd and pending_ovf into ovf.
  - Set done=1 for exactly the next cycle; go to IDLE.
- Latency: start accepted at E0, bcd/done valid in the cycle after edge E0+WIDTH, i.e. WIDTH cycles after acceptance.
- busy == (state==SHIFT): high for exactly WIDTH cycles per conversion.
- start while busy is ignored and not queued.
- Back-to-back operation: start is accepted in the same cycle done is high, because state is already IDLE.
  - Throughput is one conversion per WIDTH+1 cycles.
- bcd and ovf never show intermediate scratch values; they change only on the done-setting edge or on reset.
- Every bcd nibble is always 0..9, so the downstream decoder never receives codes A–F.
- Arithmetic: add-3 is applied per nibble; no carry between nibbles.
  - Saturation to MAXV guarantees the result fits in DIGITS digits.
  - The comparison bin > MAXV is unsigned and at least max(WIDTH, bits of MAXV) wide.

Optional Feature:
- Macro: BIN2BCD_AUTO_CONVERT_EN.
- Defined:
  - Internal register last_bin (WIDTH bits, reset 0) holds the operand last accepted.
  - In IDLE, a conversion starts automatically whenever bin != last_bin, regardless of start; start is still honoured.
  - last_bin is updated with the raw bin on each acceptance.
  - Result: bcd tracks a changing bin without external sequencing.
  - Immediately after reset, bin=0 triggers no conversion; bcd is already 0.
- Undefined: conversions start only on start; no last_bin register.

Test Plan:
- Default params, bin=0, start pulse → busy for 10 cycles, then done=1 for one cycle, bcd=12'h000, ovf=0.
- bin=255, start at edge E0 → done high exactly in the cycle after edge E0+10, bcd=12'h255, ovf=0; bcd holds 12'h000 until then.
- bin=999 → bcd=12'h999, ovf=0; then bin=1000 → bcd=12'h999, ovf=1; then bin=1023 → bcd=12'h999, ovf=1.
- Start bin=42; 3 cycles later set bin=7 with start=1 while busy → result bcd=12'h042; a single done pulse; start ignored.
- Start bin=500; assert rst_n=0 on cycle 5 of SHIFT → outputs zero, no done pulse; after release, start bin=123 → bcd=12'h123.
- done cycle with start=1 and bin=86 → new conversion accepted with no idle gap, busy high the next cycle, bcd=12'h086 10 cycles later.
  - With BIN2BCD_AUTO_CONVERT_EN defined: change bin 0→317 with start=0 → conversion runs automatically, bcd=12'h317.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
//
// State table:
//   IDLE  | waiting for a conversion request; outputs hold the last result
//   SHIFT | double-dabble in progress, one operand bit consumed per clock
//
// Ports:
//   clk    in   single clock, rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   conversion request, sampled only in IDLE
//   bin    in   unsigned binary value [WIDTH-1:0], sampled when start is accepted
//   busy   out  high while a conversion is in progress
//   done   out  one-cycle pulse when a new result is written to bcd
//   ovf    out  last accepted bin exceeded 10^DIGITS-1 (result saturated)
//   bcd    out  packed BCD result [4*DIGITS-1:0], most-significant digit on top
//
// Optional feature macro: BIN2BCD_AUTO_CONVERT_EN
//   When defined, a conversion also starts automatically in IDLE whenever bin
//   differs from the value last accepted.

module bin2bcd_seq #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd
);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int     BW        = 4 * DIGITS;
  localparam longint MAXV      = pow10(DIGITS) - 1;
  localparam int     MAXV_BITS = $clog2(MAXV + 1);
  // Compare wide enough to hold both bin and MAXV without truncation.
  localparam int     CW        = (WIDTH > MAXV_BITS) ? WIDTH : MAXV_BITS;
  localparam int     CNT_W     = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic [WIDTH-1:0]   operand;
  logic [BW-1:0]      scratch;
  logic [CNT_W-1:0]   count;
  logic               pending_ovf;

  logic [CW-1:0]      bin_ext;
  logic [CW-1:0]      maxv_c;
  logic               over;
  logic [WIDTH-1:0]   bin_sat;
  logic [BW-1:0]      scratch_adj;
  logic [BW-1:0]      scratch_shift;
  logic               trigger;

  assign bin_ext = CW'(bin);
  assign maxv_c  = CW'(MAXV);
  assign over    = (bin_ext > maxv_c);
  // When over is possible, MAXV fits in WIDTH bits, so the truncation is lossless.
  assign bin_sat = over ? WIDTH'(maxv_c) : bin;

  // Per-nibble add-3 correction; nibbles never carry into each other.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  assign scratch_shift = {scratch_adj[BW-2:0], operand[WIDTH-1]};

`ifdef BIN2BCD_AUTO_CONVERT_EN
  logic [WIDTH-1:0] last_bin;

  assign trigger = start | (bin != last_bin);

  always_ff @(posedge clk) begin
    if (!rst_n)
      last_bin <= '0;
    else if (state == IDLE && trigger)
      last_bin <= bin;
  end
`else
  assign trigger = start;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      bcd         <= '0;
      operand     <= '0;
      scratch     <= '0;
      count       <= '0;
      pending_ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            operand     <= bin_sat;
            pending_ovf <= over;
            scratch     <= '0;
            count       <= CNT_W'(WIDTH);
            state       <= SHIFT;
            busy        <= 1'b1;
          end
        end
        SHIFT: begin
          scratch <= scratch_shift;
          operand <= {operand[WIDTH-2:0], 1'b0};
          count   <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            bcd   <= scratch_shift;
            ovf   <= pending_ovf;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  bin = '0;
  logic        busy, done, ovf;
  logic [11:0] bcd;

  int n_checks = 0;
  int n_fail   = 0;

  bin2bcd_seq #(.WIDTH(10), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .ovf(ovf), .bcd(bcd)
  );

  always #5 clk = ~clk;

  // Reference: saturate to 999, then split into decimal digits.
  function automatic logic [11:0] model_bcd(input int v);
    int s;
    s = (v > 999) ? 999 : v;
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  // Launches one conversion at the current negedge and returns at the negedge
  // where done is high (or after a bounded wait). Inputs are scrambled after
  // acceptance to show the operand was latched.
  task automatic convert(input int v, input string name);
    logic [11:0] prev;
    int lat;
    prev  = bcd;
    start = 1'b1;
    bin   = 10'(v);
    @(negedge clk);
    start = 1'b0;
    bin   = 10'($urandom);
    lat   = 0;
    while (!done && lat < 20) begin
      n_checks++;
      if (busy !== 1'b1 || bcd !== prev) begin
        n_fail++;
        $display("FAIL %s busy/hold lat=%0d: busy=%b bcd=%h, required busy=1 bcd=%h", name, lat, busy, bcd, prev);
      end
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (done !== 1'b1 || lat !== 10) begin
      n_fail++;
      $display("FAIL %s latency: done=%b after %0d cycles, required done=1 after 10", name, done, lat);
    end
    n_checks++;
    if (bcd !== model_bcd(v) || ovf !== (v > 999) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result: bcd=%h ovf=%b busy=%b, required bcd=%h ovf=%b busy=0", name, bcd, ovf, busy, model_bcd(v), (v > 999));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, ovf, bcd} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b ovf=%b bcd=%h, required all zero", busy, done, ovf, bcd);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    convert(0, "zero");
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero pulse width: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_saturation();
    convert(255, "v255");
    @(negedge clk);
    convert(999, "v999");
    @(negedge clk);
    convert(1000, "v1000");
    @(negedge clk);
    convert(1023, "v1023");
    @(negedge clk);
    convert(5, "v5");
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int pulses;
    pulses = 0;
    fork
      convert(42, "busy_ignore");
      begin
        repeat (3) @(negedge clk);
        start = 1'b1;
        bin   = 10'd7;
        @(negedge clk);
        start = 1'b0;
      end
    join
    for (int i = 0; i < 15; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    n_checks++;
    if (pulses !== 1 || bcd !== 12'h042 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore: pulses=%0d bcd=%h busy=%b, required 1 042 0", pulses, bcd, busy);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    pulses = 0;
    start = 1'b1;
    bin   = 10'd500;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({busy, done, ovf, bcd} !== 15'd0) begin
      n_fail++;
      $display("FAIL abort outputs: busy=%b done=%b ovf=%b bcd=%h, required all zero", busy, done, ovf, bcd);
    end
    for (int i = 0; i < 14; i++) begin
      if (done || busy) pulses++;
      @(negedge clk);
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL abort no_done: %0d busy/done cycles, required 0", pulses);
    end
    convert(123, "after_abort");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    convert(300, "b2b_first");
    // done is high now; request the next conversion in this same cycle.
    convert(86, "b2b_second");
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      convert(int'($urandom_range(0, 1023)), "random");
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_zero();
    test_saturation();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
